// File: rtl/btn_debounce.sv
// Four-button synchronizer/debouncer with a shared single-pulse arbiter.
// Each button emits at most one pulse per qualified press; only one output is ever high.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_MS  = 20,
    parameter int unsigned PULSE_CYCLES = 1
) (
    input  logic clk_1kHz,
    input  logic rst,
    input  logic sw6,
    input  logic btn_7,
    input  logic btn_6,
    input  logic btn_5,
    input  logic btn_4,
    output logic btn_7_out,
    output logic btn_6_out,
    output logic btn_5_out,
    output logic btn_4_out,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_MS - 1);
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES);

    logic [3:0] raw;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] qual;
    logic [3:0] winner;
    logic [3:0] pulse;
    logic [3:0] pcnt;

    state_t     state      [4];
    state_t     state_next [4];
    logic [7:0] cnt        [4];
    logic [7:0] cnt_next   [4];

    // Bit 3 is BTN7 (highest priority) down to bit 0 for BTN4.
    assign raw = {btn_7, btn_6, btn_5, btn_4};

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Reset parks every button in RELEASE_WAIT so a button held through reset
    // must be seen released before it can qualify again.
    always_ff @(posedge clk_1kHz) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (rst) begin
                state[i] <= RELEASE_WAIT;
                cnt[i]   <= '0;
            end else begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            unique case (state[i])
                IDLE: begin
                    if (s2[i]) begin
                        state_next[i] = PRESS_WAIT;
                        cnt_next[i]   = 8'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2[i]) begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_next[i] = PRESSED;
                    end else begin
                        cnt_next[i] = cnt[i] + 8'd1;
                    end
                end
                PRESSED: begin
                    state_next[i] = RELEASE_WAIT;
                    cnt_next[i]   = '0;
                end
                RELEASE_WAIT: begin
                    if (s2[i]) begin
                        cnt_next[i] = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            qual[i] = (state[i] == PRESS_WAIT) && s2[i] && (cnt[i] == CNT_LAST);
        end
    end

    always_comb begin
        winner = '0;
        if (qual[3]) begin
            winner = 4'b1000;
        end else if (qual[2]) begin
            winner = 4'b0100;
        end else if (qual[1]) begin
            winner = 4'b0010;
        end else if (qual[0]) begin
            winner = 4'b0001;
        end
    end

    // busy is judged on pcnt before its decrement, so a press landing on the
    // final pulse cycle is consumed without a pulse.
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            pcnt  <= '0;
            pulse <= '0;
        end else if (pcnt != '0) begin
            pcnt <= pcnt - 4'd1;
            if (pcnt == 4'd1) begin
                pulse <= '0;
            end
        end else if (sw6 && (qual != '0)) begin
            pulse <= winner;
            pcnt  <= PULSE_LOAD;
        end
    end

    assign btn_7_out = pulse[3];
    assign btn_6_out = pulse[2];
    assign btn_5_out = pulse[1];
    assign btn_4_out = pulse[0];
    assign busy      = (pcnt != '0);

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a run-length reference model predicts each
// pulse (button, start edge); a negedge monitor matches what the DUT emits.
module tb_btn_debounce;

    localparam int D = 20;
    localparam int P = 4;

    logic clk_1kHz;
    logic rst;
    logic sw6;
    logic btn_7, btn_6, btn_5, btn_4;
    logic btn_7_out, btn_6_out, btn_5_out, btn_4_out;
    logic busy;

    btn_debounce #(
        .DEBOUNCE_MS (D),
        .PULSE_CYCLES(P)
    ) dut (
        .clk_1kHz (clk_1kHz),
        .rst      (rst),
        .sw6      (sw6),
        .btn_7    (btn_7),
        .btn_6    (btn_6),
        .btn_5    (btn_5),
        .btn_4    (btn_4),
        .btn_7_out(btn_7_out),
        .btn_6_out(btn_6_out),
        .btn_5_out(btn_5_out),
        .btn_4_out(btn_4_out),
        .busy     (busy)
    );

    initial begin
        clk_1kHz = 1'b0;
        forever #5 clk_1kHz = ~clk_1kHz;
    end

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses    [4];
    int last_rise [4];
    int last_width = 0;
    logic rst_seen = 1'b0;

    // Reference model: a button is "armed" after D consecutive low samples;
    // while armed, D consecutive high samples make a press, after which one
    // sample is ignored before low-run counting begins again.
    typedef enum int {ARMED, HOLDOFF, RELEASING} mphase_t;
    mphase_t phase  [4];
    int      hi_run [4];
    int      lo_run [4];
    logic [3:0] m_s1, m_s2;
    int      rem;

    task automatic model_reset();
        m_s1 = '0;
        m_s2 = '0;
        rem  = 0;
        for (int i = 0; i < 4; i++) begin
            phase[i]  = RELEASING;
            hi_run[i] = 0;
            lo_run[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] q;
        logic [3:0] rawv;
        exp_t e;
        rawv = {btn_7, btn_6, btn_5, btn_4};
        rst_seen = rst;
        if (rst) begin
            model_reset();
        end else begin
            q = '0;
            for (int i = 0; i < 4; i++) begin
                case (phase[i])
                    ARMED: begin
                        if (m_s2[i]) begin
                            hi_run[i]++;
                            if (hi_run[i] == D) begin
                                q[i] = 1'b1;
                                phase[i] = HOLDOFF;
                            end
                        end else begin
                            hi_run[i] = 0;
                        end
                    end
                    HOLDOFF: begin
                        phase[i]  = RELEASING;
                        lo_run[i] = 0;
                    end
                    default: begin
                        if (!m_s2[i]) begin
                            lo_run[i]++;
                            if (lo_run[i] == D) begin
                                phase[i]  = ARMED;
                                hi_run[i] = 0;
                            end
                        end else begin
                            lo_run[i] = 0;
                        end
                    end
                endcase
            end
            if (rem > 0) begin
                rem--;
            end else if (sw6 && q != '0) begin
                e.cyc = cyc;
                e.idx = q[3] ? 3 : q[2] ? 2 : q[1] ? 1 : 0;
                sbq.push_back(e);
                rem = P;
            end
            m_s2 = m_s1;
            m_s1 = rawv;
        end
        cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_1kHz);
            model_step();
        end
    end

    // Monitor
    logic [3:0] cur, prev;
    int width = 0;
    int ridx;
    exp_t got;

    initial begin
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            pulses[i]    = 0;
            last_rise[i] = -1;
        end
        forever begin
            @(negedge clk_1kHz);
            cur = {btn_7_out, btn_6_out, btn_5_out, btn_4_out};
            n_checks++;
            if (busy !== (cur != '0) || $countones(cur) > 1) begin
                n_fail++;
                $display("FAIL out_consistency: cycle %0d out=%b busy=%b, required one-hot out and busy=(out!=0)",
                         cyc - 1, cur, busy);
            end
            if (cur != '0 && prev == '0) begin
                width = 1;
                ridx = cur[3] ? 3 : cur[2] ? 2 : cur[1] ? 1 : 0;
                pulses[ridx]++;
                last_rise[ridx] = cyc - 1;
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL pulse_unexpected: button %0d pulsed at edge %0d, required no pulse",
                             ridx + 4, cyc - 1);
                end else begin
                    got = sbq.pop_front();
                    if (got.idx != ridx || got.cyc != cyc - 1) begin
                        n_fail++;
                        $display("FAIL pulse_match: got button %0d at edge %0d, required button %0d at edge %0d",
                                 ridx + 4, cyc - 1, got.idx + 4, got.cyc);
                    end
                end
            end else if (cur != '0) begin
                width++;
                n_checks++;
                if (cur != prev) begin
                    n_fail++;
                    $display("FAIL pulse_stable: out changed %b -> %b mid-pulse, required unchanged", prev, cur);
                end
            end else if (prev != '0 && !rst_seen) begin
                last_width = width;
                n_checks++;
                if (width != P) begin
                    n_fail++;
                    $display("FAIL pulse_width: got %0d cycles, required %0d", width, P);
                end
            end
            prev = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_1kHz);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    int base [4];
    int m;
    int hold [4];
    logic [3:0] rb;
    bit seen;

    task automatic snap();
        for (int i = 0; i < 4; i++) base[i] = pulses[i];
    endtask

    initial begin
        rst = 1'b1;
        sw6 = 1'b1;
        {btn_7, btn_6, btn_5, btn_4} = '0;
        tick(3);
        check("reset_outs", int'({btn_7_out, btn_6_out, btn_5_out, btn_4_out}), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        tick(30);

        // Clean press
        snap();
        btn_6 = 1'b1;
        m = cyc - 1;
        tick(50);
        check("clean_count", pulses[2] - base[2], 1);
        check("clean_latency", last_rise[2], m + 2 + D);
        btn_6 = 1'b0;
        tick(30);

        // Bounce, then hold
        snap();
        for (int k = 0; k < 10; k++) begin
            btn_5 = ~btn_5;
            tick(3);
        end
        check("bounce_no_pulse", pulses[1] - base[1], 0);
        btn_5 = 1'b1;
        m = cyc - 1;
        tick(40);
        check("bounce_count", pulses[1] - base[1], 1);
        check("bounce_latency", last_rise[1], m + 2 + D);
        btn_5 = 1'b0;
        tick(30);

        // Simultaneous press
        snap();
        btn_7 = 1'b1;
        btn_4 = 1'b1;
        tick(60);
        check("simul_btn7", pulses[3] - base[3], 1);
        check("simul_btn4", pulses[0] - base[0], 0);
        btn_7 = 1'b0;
        tick(40);
        check("simul_btn4_held", pulses[0] - base[0], 0);
        btn_4 = 1'b0;
        tick(30);
        btn_4 = 1'b1;
        tick(30);
        check("simul_btn4_repress", pulses[0] - base[0], 1);
        btn_4 = 1'b0;
        tick(30);

        // Enable gating
        snap();
        sw6 = 1'b0;
        btn_4 = 1'b1;
        tick(40);
        check("gate_off", pulses[0] - base[0], 0);
        sw6 = 1'b1;
        tick(40);
        check("gate_on_held", pulses[0] - base[0], 0);
        btn_4 = 1'b0;
        tick(30);
        btn_4 = 1'b1;
        tick(30);
        check("gate_repress", pulses[0] - base[0], 1);
        btn_4 = 1'b0;
        tick(30);

        // Reset while held
        snap();
        btn_7 = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(100);
        check("rst_held", pulses[3] - base[3], 0);
        btn_7 = 1'b0;
        tick(25);
        btn_7 = 1'b1;
        tick(30);
        check("rst_repress", pulses[3] - base[3], 1);
        btn_7 = 1'b0;
        tick(30);

        // Busy window: btn_6 qualifies 2 cycles into btn_7's pulse
        snap();
        btn_7 = 1'b1;
        tick(2);
        btn_6 = 1'b1;
        tick(40);
        check("busy_btn7", pulses[3] - base[3], 1);
        check("busy_btn6", pulses[2] - base[2], 0);
        check("busy_width", last_width, P);
        btn_7 = 1'b0;
        btn_6 = 1'b0;
        tick(30);

        // Reset mid-pulse
        btn_5 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick(1);
            seen = btn_5_out;
        end
        check("midrst_pulse_seen", int'(seen), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_out", int'(btn_5_out), 0);
        check("midrst_busy", int'(busy), 0);
        btn_5 = 1'b0;
        tick(30);

        // Randomized bouncy buttons with occasional enable toggles and resets
        rb = '0;
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(5, 60);
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    rb[i] = ~rb[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
                end else begin
                    hold[i]--;
                end
            end
            if (sw6 && $urandom_range(0, 299) == 0) sw6 = 1'b0;
            else if (!sw6 && $urandom_range(0, 39) == 0) sw6 = 1'b1;
            rst = ($urandom_range(0, 2999) == 0);
            {btn_7, btn_6, btn_5, btn_4} = rb;
            tick(1);
        end

        rst = 1'b0;
        sw6 = 1'b1;
        {btn_7, btn_6, btn_5, btn_4} = '0;
        tick(40);
        check("sb_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
